// File: rtl/iram_pkg.sv
// iram_pkg: shared state encoding and default geometry for the loadable instruction memory.
package iram_pkg;
    typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF = 128;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
    localparam int WORD_IDX_W = $clog2(DEPTH_DEF);
    localparam logic NOP_WORD = 1'b0;
endpackage

// File: rtl/iram_byte_packer.sv
// iram_byte_packer: assembles MSB-first bytes into words, flagging the word on its last byte.
module iram_byte_packer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);
    localparam int BPW = DATA_W / 8;
    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-9:0]   sr_q, sr_d;
    assign word = {sr_q, byte_in};
    assign word_valid = byte_valid && (cnt_q == CW'(BPW - 1));
    always_comb begin
        cnt_d = start ? '0 : word_valid ? '0 : byte_valid ? cnt_q + 1'b1 : cnt_q;
        sr_d = byte_valid ? word[DATA_W-9:0] : sr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q <= sr_d;
        end
    end
endmodule

// File: rtl/iram_loadable.sv
// iram_loadable: combinational-fetch instruction store, zero-filled after reset and
// reloadable at runtime through a byte-stream valid/ready port.
module iram_loadable
    import iram_pkg::*;
#(
    parameter int DATA_W = BYTES_PER_WORD * 8,
    parameter int DEPTH = 2 ** WORD_IDX_W,
    parameter int ADDR_W = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [ADDR_W-1:0]         ADDR,
    output logic [DATA_W-1:0]         Q,
    output logic                      MISALIGN,
    output logic                      BUSY,
    input  logic                      LD_START,
    input  logic [$clog2(DEPTH):0]    LD_LEN,
    input  logic [7:0]                LD_BYTE,
    input  logic                      LD_VALID,
    output logic                      LD_READY,
    output logic                      LD_DONE,
    output logic                      LD_ERR,
    output logic [7:0]                CHKSUM
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam int BPW = DATA_W / 8;
    localparam int OW = $clog2(BPW);
    localparam int XW = ADDR_W - OW;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic              err_q, err_d, done_q, done_d, ready_q, ready_d;
    logic              acc, we, pk_start, pk_valid;
    logic [DATA_W-1:0] wdata, pk_word;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [XW-1:0]     widx;

    iram_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk(CLK),
        .rst(RESET),
        .start(pk_start),
        .byte_in(LD_BYTE),
        .byte_valid(acc),
        .word_valid(pk_valid),
        .word(pk_word)
    );

    assign BUSY = state_q != RUN;
    assign widx = ADDR[ADDR_W-1:OW];
    assign Q = (BUSY || ({1'b0, widx} >= (XW + 1)'(DEPTH))) ? '0 : mem[widx[IW-1:0]];
    assign MISALIGN = !BUSY && (ADDR[OW-1:0] != '0);
    assign LD_READY = ready_q;
    assign LD_DONE = done_q;
    assign LD_ERR = err_q;
    assign CHKSUM = chk_q;
    assign acc = LD_VALID && ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        len_d = len_q;
        chk_d = chk_q;
        err_d = err_q;
        done_d = 1'b0;
        pk_start = 1'b0;
        we = 1'b0;
        wdata = pk_word;
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                wdata = {DATA_W{NOP_WORD}};
                ptr_d = ptr_q + 1'b1;
                state_d = (ptr_q == IW'(DEPTH - 1)) ? RUN : CLEAR;
            end
            RUN: begin
                if (LD_START && (LD_LEN == '0 || LD_LEN > LW'(DEPTH))) begin
                    err_d = 1'b1;
                end else if (LD_START) begin
                    err_d = 1'b0;
                    chk_d = '0;
                    ptr_d = '0;
                    len_d = LD_LEN;
                    pk_start = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                chk_d = acc ? chk_q ^ LD_BYTE : chk_q;
                we = pk_valid;
                ptr_d = pk_valid ? ptr_q + 1'b1 : ptr_q;
                // Leaving on the final word's edge makes BUSY, LD_DONE and CHKSUM settle together.
                done_d = pk_valid && (LW'(ptr_q) + 1'b1 == len_q);
                state_d = done_d ? RUN : LOAD;
            end
            default: state_d = CLEAR;
        endcase
        ready_d = state_d == LOAD;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= CLEAR;
            ptr_q <= '0;
            len_q <= '0;
            chk_q <= '0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            len_q <= len_d;
            chk_q <= chk_d;
            err_q <= err_d;
            done_q <= done_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[ptr_q] <= wdata;
    end
endmodule

// File: tb/tb_iram_loadable.sv
// tb_iram_loadable: randomized loads and fetches against a word-array model with a
// queue-based scoreboard for fetch results and load-completion checksums.
module tb_iram_loadable;
    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  ADDR = '0;
    logic [15:0] Q;
    logic        MISALIGN, BUSY, LD_READY, LD_DONE, LD_ERR;
    logic        LD_START = 1'b0;
    logic [7:0]  LD_LEN = '0;
    logic [7:0]  LD_BYTE = '0;
    logic        LD_VALID = 1'b0;
    logic [7:0]  CHKSUM;

    iram_loadable dut (
        .CLK(clk), .RESET(RESET), .ADDR(ADDR), .Q(Q), .MISALIGN(MISALIGN), .BUSY(BUSY),
        .LD_START(LD_START), .LD_LEN(LD_LEN), .LD_BYTE(LD_BYTE), .LD_VALID(LD_VALID),
        .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_ERR(LD_ERR), .CHKSUM(CHKSUM)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [15:0] model [128];
    logic [7:0]  ld_bytes [$];
    logic [17:0] rd_q [$];
    logic [7:0]  done_q [$];
    bit rd_en = 0, done_prev = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            check("fetch_queue", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) check("fetch", {BUSY, MISALIGN, Q}, rd_q.pop_front());
        end
        if (LD_DONE) begin
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) check("chksum", CHKSUM, done_q.pop_front());
        end
        if (done_prev) check("done_pulse", LD_DONE, 0);
        done_prev = LD_DONE;
    end

    task automatic do_read(input logic [7:0] a);
        @(posedge clk); #1;
        ADDR = a;
        rd_q.push_back({1'b0, a[0], model[a[7:1]]});
        rd_en = 1;
        @(negedge clk); #1;
        rd_en = 0;
    endtask

    task automatic wait_clear(input bit poke);
        int c;
        c = 0;
        ADDR = 8'h10;
        @(negedge clk);
        while (BUSY && c < 1000) begin
            c++;
            if (poke && c == 5) begin LD_LEN = 8'd2; LD_START = 1; end
            if (c == 6) LD_START = 0;
            if (poke && c == 10) begin
                check("ready_in_clear", LD_READY, 0);
                check("err_in_clear", LD_ERR, 0);
            end
            if (c == 20) check("q_while_busy", Q, 0);
            @(negedge clk);
        end
        check("clear_cycles", c, 128);
        for (int i = 0; i < 128; i++) model[i] = 16'h0;
    endtask

    task automatic do_load(input int len, input bit gaps, input int abort_at);
        int n, got, nb;
        logic [7:0] chk;
        bit a;
        nb = len * 2;
        chk = 0;
        @(posedge clk); #1;
        LD_START = 1;
        LD_LEN = len[7:0];
        @(posedge clk); #1;
        LD_START = 0;
        if (len < 1 || len > 128) begin
            @(negedge clk);
            check("ld_err_set", LD_ERR, 1);
            check("busy_after_err", BUSY, 0);
            check("ready_after_err", LD_READY, 0);
            return;
        end
        for (int i = 0; i < nb; i++) chk ^= ld_bytes[i];
        done_q.push_back(chk);
        n = 0;
        got = 0;
        while (got < nb && n < 4 * nb + 20) begin
            if (got == abort_at) begin
                LD_VALID = 0;
                RESET = 1;
                void'(done_q.pop_back());
                @(negedge clk);
                check("abort_chksum", CHKSUM, 0);
                check("abort_busy", BUSY, 1);
                check("abort_ready", LD_READY, 0);
                @(posedge clk); #1;
                RESET = 0;
                return;
            end
            LD_VALID = gaps ? n[0] : 1'b1;
            LD_BYTE = ld_bytes[got];
            @(negedge clk);
            if (n == 0) check("err_cleared", LD_ERR, 0);
            a = LD_READY && LD_VALID;
            @(posedge clk); #1;
            n++;
            if (a) got++;
        end
        LD_VALID = 0;
        check("load_cycles", n, gaps ? 2 * nb : nb);
        @(negedge clk);
        check("done_seen", LD_DONE, 1);
        check("busy_after_load", BUSY, 0);
        for (int w = 0; w < len; w++) model[w] = {ld_bytes[2 * w], ld_bytes[2 * w + 1]};
    endtask

    task automatic rand_bytes(input int len);
        ld_bytes.delete();
        for (int i = 0; i < 2 * len; i++) ld_bytes.push_back(8'($urandom));
    endtask

    initial begin
        int len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", BUSY, 1);
        check("rst_ready", LD_READY, 0);
        check("rst_done", LD_DONE, 0);
        check("rst_err", LD_ERR, 0);
        check("rst_chksum", CHKSUM, 0);
        @(posedge clk); #1;
        RESET = 0;
        wait_clear(1);
        do_read(8'h00);
        do_read(8'hFE);
        ld_bytes = '{8'hF0, 8'h01, 8'hF2, 8'h91};
        do_load(2, 0, -1);
        do_read(8'h00);
        do_read(8'h02);
        do_read(8'h04);
        do_read(8'h03);
        rand_bytes(3);
        do_load(3, 0, -1);
        ld_bytes = '{8'hF0, 8'h01, 8'hF2, 8'h91};
        do_load(2, 1, -1);
        do_read(8'h00);
        do_read(8'h02);
        do_read(8'h04);
        do_load(0, 0, -1);
        do_load(129, 0, -1);
        for (int k = 0; k < 4; k++) begin
            len = (k == 0) ? 128 : int'($urandom_range(1, 128));
            rand_bytes(len);
            do_load(len, k[0], -1);
            for (int r = 0; r < 12; r++) do_read(8'($urandom));
        end
        do_read(8'hFF);
        rand_bytes(2);
        do_load(2, 0, 3);
        wait_clear(1);
        check("chksum_after_abort", CHKSUM, 0);
        for (int i = 0; i < 128; i++) do_read(8'(2 * i));
        @(negedge clk);
        check("pending_done", done_q.size(), 0);
        check("pending_fetch", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
